// File: rtl/med_pkg.sv
// med_pkg: shared definitions for the multi-channel edge detector.
//   - edge_mode_e : per-channel edge mode encodings (off / rise / fall / both)
//   - MODE_W      : width of one channel's mode field
//   - clog2       : ceiling log2, used to size the stability filter counter
package med_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// edge_chan: one channel of the edge detector.
//   sig_in -> SYNC_STAGES-flop synchroniser -> stability filter (level) ->
//   edge qualification by mode -> registered pulse/direction, sticky status
//   and saturating event counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sig_in       raw asynchronous input
//   mode         edge mode (edge_mode_e encoding)
//   status_clr   write-1-to-clear for status (a simultaneous edge wins)
//   cnt_clr      counter clear (a simultaneous edge leaves the counter at 1)
//   edge_pulse   one-cycle pulse per qualified edge
//   edge_dir     direction of the last qualified edge (1 rise, 0 fall)
//   level        filtered, synchronised level
//   status       sticky event flag
//   evt_cnt      saturating event counter
module edge_chan
    import med_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic [MODE_W-1:0] mode,
    input  logic              status_clr,
    input  logic              cnt_clr,
    output logic              edge_pulse,
    output logic              edge_dir,
    output logic              level,
    output logic              status,
    output logic [CNT_W-1:0]  evt_cnt
);

    localparam int               FC_W    = clog2(FILT_LEN) + 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_s;

    logic [FC_W-1:0]  fc_reg, fc_next;
    logic             level_reg, level_next;
    logic             pulse_reg, pulse_next;
    logic             dir_reg, dir_next;
    logic             status_reg, status_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic raw_edge;
    logic rising;
    logic qual;

    assign sync_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        fc_next    = fc_reg;
        level_next = level_reg;
        raw_edge   = 1'b0;
        // fc counts consecutive cycles in which the synchronised input has
        // disagreed with level; any agreement restarts the count, so only
        // disagreements lasting FILT_LEN cycles move level.
        if (sync_s == level_reg) begin
            fc_next = '0;
        end else if (fc_reg == FC_LAST) begin
            level_next = sync_s;
            fc_next    = '0;
            raw_edge   = 1'b1;
        end else begin
            fc_next = fc_reg + 1'b1;
        end

        // level is about to take the value of sync_s, so that value is the
        // direction of the edge.
        rising = sync_s;
        qual   = 1'b0;
        if (raw_edge) begin
            case (edge_mode_e'(mode))
                MODE_RISE: qual = rising;
                MODE_FALL: qual = ~rising;
                MODE_BOTH: qual = 1'b1;
                default:   qual = 1'b0;
            endcase
        end

        pulse_next = qual;
        dir_next   = qual ? rising : dir_reg;

        // Set has priority over clear.
        if (qual) begin
            status_next = 1'b1;
        end else if (status_clr) begin
            status_next = 1'b0;
        end else begin
            status_next = status_reg;
        end

        // Clear has priority over increment, but an edge in the clearing
        // cycle is still counted.
        if (cnt_clr) begin
            cnt_next = qual ? CNT_W'(1) : '0;
        end else if (qual && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg   <= '0;
            fc_reg     <= '0;
            level_reg  <= 1'b0;
            pulse_reg  <= 1'b0;
            dir_reg    <= 1'b0;
            status_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            fc_reg     <= fc_next;
            level_reg  <= level_next;
            pulse_reg  <= pulse_next;
            dir_reg    <= dir_next;
            status_reg <= status_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign edge_pulse = pulse_reg;
    assign edge_dir   = dir_reg;
    assign level      = level_reg;
    assign status     = status_reg;
    assign evt_cnt    = cnt_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: CH independent edge-event channels plus a maskable
// interrupt formed from the sticky status flags.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sig_in       raw asynchronous inputs, bit i = channel i
//   mode         per-channel edge mode, [2i+1:2i] for channel i
//   irq_en       per-channel interrupt enable
//   status_clr   per-channel write-1-to-clear for status
//   cnt_clr      per-channel counter clear
//   edge_pulse   per-channel one-cycle qualified edge pulse
//   edge_dir     per-channel direction of the last pulse (1 rise, 0 fall)
//   level        per-channel filtered level
//   status       per-channel sticky event flag
//   evt_cnt      per-channel saturating counters, channel i at [i*CNT_W +: CNT_W]
//   irq          |(status & irq_en)
module multi_edge_detector
    import med_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH-1:0]        sig_in,
    input  logic [MODE_W*CH-1:0] mode,
    input  logic [CH-1:0]        irq_en,
    input  logic [CH-1:0]        status_clr,
    input  logic [CH-1:0]        cnt_clr,
    output logic [CH-1:0]        edge_pulse,
    output logic [CH-1:0]        edge_dir,
    output logic [CH-1:0]        level,
    output logic [CH-1:0]        status,
    output logic [CH*CNT_W-1:0]  evt_cnt,
    output logic                 irq
);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            edge_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_LEN    (FILT_LEN),
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .sig_in     (sig_in[gi]),
                .mode       (mode[MODE_W*gi +: MODE_W]),
                .status_clr (status_clr[gi]),
                .cnt_clr    (cnt_clr[gi]),
                .edge_pulse (edge_pulse[gi]),
                .edge_dir   (edge_dir[gi]),
                .level      (level[gi]),
                .status     (status[gi]),
                .evt_cnt    (evt_cnt[CNT_W*gi +: CNT_W])
            );
        end
    endgenerate

    // Built from registered status, so irq is glitch-free apart from irq_en.
    assign irq = |(status & irq_en);

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

    localparam int CH  = 8;
    localparam int SS  = 2;
    localparam int FL  = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CH-1:0]     sig_in = '0;
    logic [2*CH-1:0]   mode = '0;
    logic [CH-1:0]     irq_en = '0;
    logic [CH-1:0]     status_clr = '0;
    logic [CH-1:0]     cnt_clr = '0;
    logic [CH-1:0]     edge_pulse;
    logic [CH-1:0]     edge_dir;
    logic [CH-1:0]     level;
    logic [CH-1:0]     status;
    logic [CH*CW-1:0]  evt_cnt;
    logic              irq;

    multi_edge_detector #(
        .CH          (CH),
        .SYNC_STAGES (SS),
        .FILT_LEN    (FL),
        .CNT_W       (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .mode       (mode),
        .irq_en     (irq_en),
        .status_clr (status_clr),
        .cnt_clr    (cnt_clr),
        .edge_pulse (edge_pulse),
        .edge_dir   (edge_dir),
        .level      (level),
        .status     (status),
        .evt_cnt    (evt_cnt),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int cyc;
        int ch;
        bit dir;
    } pulse_t;

    pulse_t exp_q[$];

    // Reference model. hist[c] bit j is the raw input seen j edges ago
    // (bit 0 = this edge). The synchroniser delays the input by SS edges, and
    // level flips once FL consecutive delayed samples all differ from it.
    logic [31:0] hist[CH];
    bit          m_lvl[CH];
    bit          m_st[CH];
    bit          m_dir[CH];
    int          m_cnt[CH];
    int          cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        bit     flip;
        bit     qual;
        bit     rising;
        pulse_t p;
        if (!rst_n) begin
            foreach (exp_q[k]) begin
                mismatched++;
                compared++;
                $display("FAIL pulse_missed ch=%0d cyc=%0d got=none want=dir%0d (lost at reset)",
                         exp_q[k].ch, exp_q[k].cyc, exp_q[k].dir);
            end
            exp_q.delete();
            for (int c = 0; c < CH; c++) begin
                hist[c]  = '0;
                m_lvl[c] = 1'b0;
                m_st[c]  = 1'b0;
                m_dir[c] = 1'b0;
                m_cnt[c] = 0;
            end
        end else begin
            cyc++;
            for (int c = 0; c < CH; c++) begin
                hist[c] = {hist[c][30:0], sig_in[c]};
                flip = 1'b1;
                for (int j = SS; j < SS + FL; j++) begin
                    if (hist[c][j] == m_lvl[c]) flip = 1'b0;
                end
                qual   = 1'b0;
                rising = 1'b0;
                if (flip) begin
                    rising   = !m_lvl[c];
                    m_lvl[c] = rising;
                    case (mode[2*c +: 2])
                        2'b01:   qual = rising;
                        2'b10:   qual = !rising;
                        2'b11:   qual = 1'b1;
                        default: qual = 1'b0;
                    endcase
                end
                if (qual) begin
                    m_st[c]  = 1'b1;
                    m_dir[c] = rising;
                    p.cyc = cyc;
                    p.ch  = c;
                    p.dir = rising;
                    exp_q.push_back(p);
                end else if (status_clr[c]) begin
                    m_st[c] = 1'b0;
                end
                if (cnt_clr[c]) m_cnt[c] = qual ? 1 : 0;
                else if (qual && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end
        end
    end

    // Monitor: pops expected pulses as the DUT presents them and checks the
    // per-channel state against the model every cycle.
    always @(negedge clk) begin
        logic [CH-1:0]    e_lvl;
        logic [CH-1:0]    e_st;
        logic [CH-1:0]    e_dir;
        logic [CH*CW-1:0] e_cnt;
        logic             e_irq;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL pulse_missed ch=%0d cyc=%0d got=none want=dir%0d",
                     exp_q[0].ch, exp_q[0].cyc, exp_q[0].dir);
            void'(exp_q.pop_front());
        end
        for (int c = 0; c < CH; c++) begin
            if (edge_pulse[c]) begin
                compared++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].ch == c) begin
                    if (edge_dir[c] !== exp_q[0].dir) begin
                        mismatched++;
                        $display("FAIL pulse_dir ch=%0d cyc=%0d got=%0d want=%0d",
                                 c, cyc, edge_dir[c], exp_q[0].dir);
                    end else begin
                        $display("pulse ch=%0d cyc=%0d dir=%0d cnt=%0d ok",
                                 c, cyc, edge_dir[c], evt_cnt[c*CW +: CW]);
                    end
                    void'(exp_q.pop_front());
                end else begin
                    mismatched++;
                    $display("FAIL pulse_unexpected ch=%0d cyc=%0d got=1 want=0", c, cyc);
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            e_lvl[c] = m_lvl[c];
            e_st[c]  = m_st[c];
            e_dir[c] = m_dir[c];
            e_cnt[c*CW +: CW] = CW'(m_cnt[c]);
        end
        e_irq = |(e_st & irq_en);
        compared += 5;
        if (level !== e_lvl) begin
            mismatched++;
            $display("FAIL level cyc=%0d got=%b want=%b", cyc, level, e_lvl);
        end
        if (status !== e_st) begin
            mismatched++;
            $display("FAIL status cyc=%0d got=%b want=%b", cyc, status, e_st);
        end
        if (edge_dir !== e_dir) begin
            mismatched++;
            $display("FAIL edge_dir_hold cyc=%0d got=%b want=%b", cyc, edge_dir, e_dir);
        end
        if (evt_cnt !== e_cnt) begin
            mismatched++;
            $display("FAIL evt_cnt cyc=%0d got=%h want=%h", cyc, evt_cnt, e_cnt);
        end
        if (irq !== e_irq) begin
            mismatched++;
            $display("FAIL irq cyc=%0d got=%b want=%b", cyc, irq, e_irq);
        end
    end

    // Inputs change 2 time units after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_all_zero(input string tag);
        compared++;
        if ({edge_pulse, edge_dir, level, status, evt_cnt, irq} !== '0) begin
            mismatched++;
            $display("FAIL %s pulse=%b dir=%b lvl=%b st=%b cnt=%h irq=%b want=all0",
                     tag, edge_pulse, edge_dir, level, status, evt_cnt, irq);
        end
    endtask

    initial begin
        #1 check_all_zero("reset_state");
        step(3);
        rst_n = 1'b1;
        // ch0 rise, ch1..ch4 both, ch5 rise, ch6 fall, ch7 off
        mode = {2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
        step(2);

        // Rise-only channel: rise reported, fall only moves level.
        sig_in[0] = 1'b1; step(12);
        sig_in[0] = 1'b0; step(12);

        // Glitch of FL-1 cycles is discarded; FL cycles passes.
        sig_in[1] = 1'b1; step(FL - 1);
        sig_in[1] = 1'b0; step(10);
        sig_in[1] = 1'b1; step(FL);
        sig_in[1] = 1'b0; step(10);

        // Both edges with interrupt, then clear.
        irq_en[2] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sig_in[2] = ~sig_in[2];
            step(10);
        end
        status_clr[2] = 1'b1; step(1);
        status_clr[2] = 1'b0; step(3);

        // Collisions: two edges first, then clears land on the third edge.
        sig_in[3] = 1'b1; step(10);
        sig_in[3] = 1'b0; step(10);
        sig_in[3] = 1'b1; step(SS + FL - 1);
        status_clr[3] = 1'b1;
        cnt_clr[3]    = 1'b1; step(1);
        status_clr[3] = 1'b0;
        cnt_clr[3]    = 1'b0; step(8);

        // Saturation.
        for (int k = 0; k < 20; k++) begin
            sig_in[4] = ~sig_in[4];
            step(FL + 2);
        end
        step(6);

        // Asynchronous reset while channel 5 is mid-filter.
        sig_in[5] = 1'b1; step(SS + 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        step(2);
        rst_n = 1'b1;
        step(12);

        // Randomised traffic, including short glitches and clear collisions.
        for (int n = 0; n < 2500; n++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(7) == 0) sig_in[c] = ~sig_in[c];
                status_clr[c] = ($urandom_range(31) == 0);
                cnt_clr[c]    = ($urandom_range(47) == 0);
                if ($urandom_range(63) == 0) mode[2*c +: 2] = 2'($urandom_range(3));
                if ($urandom_range(63) == 0) irq_en[c] = ~irq_en[c];
            end
            step(1);
        end
        status_clr = '0;
        cnt_clr    = '0;
        step(20);
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL pending_pulses got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- CH-channel edge-event detector for asynchronous status and GPIO lines.
- Per channel: N-stage synchroniser, stability (glitch) filter and per-channel selectable edge mode (off/rise/fall/both).
- Per channel outputs: one-cycle edge pulses with direction, sticky status with write-1-to-clear, saturating event counters.
- Status is OR-reduced into a maskable interrupt. Sits between raw pins and the register/interrupt block.

Parameters:
- CH, 8, number of independent channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_LEN, 4, consecutive stable cycles required before the filtered level follows the input (>=1; 1 = no filtering).
- CNT_W, 16, width of each per-channel event counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  CH  raw asynchronous inputs, bit i = channel i.
- mode  in  2*CH  edge mode, bits [2i+1:2i] for channel i: 00 off, 01 rise, 10 fall, 11 both.
- irq_en  in  CH  per-channel interrupt enable.
- status_clr  in  CH  write-1-to-clear pulses for status.
- cnt_clr  in  CH  clear pulses for event counters.
- edge_pulse  out  CH  one-cycle pulse per qualified edge.
- edge_dir  out  CH  direction of the current pulse: 1 rise, 0 fall; valid only with edge_pulse.
- level  out  CH  filtered, synchronised level.
- status  out  CH  sticky event flags.
- evt_cnt  out  CH*CNT_W  saturating counters, channel i at [i*CNT_W +: CNT_W].
- irq  out  1  |(status & irq_en).

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser flops, level, filter counters, edge_pulse, edge_dir, status and evt_cnt go to 0; irq therefore 0.
- Synchroniser: sig_in[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Filter, per channel, with counter fc of width clog2(FILT_LEN)+1:
  - If s == level: fc <= 0.
  - Else if fc == FILT_LEN-1: level <= s, fc <= 0, raw edge detected.
  - Else: fc <= fc+1.
  - Any return of s to level before the threshold resets fc, so pulses shorter than FILT_LEN cycles are discarded.
- Latency: a clean input step sampled at clock edge k updates level, and asserts edge_pulse (if qualified), at edge k+SYNC_STAGES+FILT_LEN-1.
- Qualification: a raw edge is qualified when mode allows its direction (rise = level 0->1). Mode 00 suppresses the pulse, status and count, but level still tracks. Mode is sampled in the same cycle as the raw edge; a mode change takes effect for the next edge.
- edge_pulse and edge_dir are registered. The pulse is exactly one cycle; edge_dir holds its last value otherwise. Back-to-back pulses are impossible when FILT_LEN>1.
- status[i]: set on a qualified edge; cleared by status_clr[i]. Simultaneous set and clear -> set wins (status stays 1).
- evt_cnt[i]: increments on a qualified edge and saturates at 2^CNT_W-1 (no wrap). cnt_clr[i] forces 0. Simultaneous clear and edge -> 1.
- irq: combinational OR of registered status & irq_en. irq_en does not affect status or counts.
- Reset mid-filter discards the pending count. A line high at reset release produces a rising edge after the latency above; this is intended (initial level is reported as 0).

Decomposition:
- Package med_pkg: mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11; function clog2.
- Sub-module edge_chan: a single channel (sync, filter, qualify, status, counter), with parameters SYNC_STAGES, FILT_LEN, CNT_W.
- The top level generates CH instances and forms irq.

Test Plan:
- Rise only: CH=8, SYNC_STAGES=2, FILT_LEN=4, mode[1:0]=01, sig_in[0] 0->1 at edge 10.
  - edge_pulse[0]=1, edge_dir[0]=1 for one cycle at edge 15; status[0]=1; evt_cnt[0]=1.
  - Then 1->0: no pulse; level[0]=0 at the corresponding edge.
- Glitch rejection: sig_in[1] high for 3 cycles, mode both -> no pulse, level[1] stays 0, fc returns to 0. Same stimulus held 4 cycles -> exactly one rise pulse.
- Both edges and irq:
  - mode[5:4]=11, irq_en[2]=1, toggle sig_in[2] 5 times with 10-cycle spacing -> 5 pulses with alternating edge_dir; evt_cnt[2]=5; irq=1.
  - status_clr[2] pulse -> irq=0 next cycle.
- Set/clear collisions: assert status_clr[3] and cnt_clr[3] on the same cycle as a qualified edge -> status[3]=1, evt_cnt[3]=1.
- Saturation: CNT_W=4, 20 qualified edges on channel 4 -> evt_cnt[4]=15 and held.
- Async reset mid-operation: drop rst_n between clock edges while channel 5 is mid-filter -> all outputs 0 immediately. After release, with sig_in[5] held 1 -> one rise pulse at release+SYNC_STAGES+FILT_LEN-1 edges.
